// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline control slice: PC-source selects and FSM states.
package pipe_ctrl_pkg;

   localparam logic [2:0] PC_SEL_SEQ  = 3'b000;
   localparam logic [2:0] PC_SEL_BR   = 3'b001;
   localparam logic [2:0] PC_SEL_JAL  = 3'b010;
   localparam logic [2:0] PC_SEL_JALR = 3'b011;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_FAULT    = 2'd2
   } state_e;

endpackage

// File: rtl/pipeline_hazard_sequencer_sat_counter.sv
// Saturating up-counter: counts cycles with inc high and holds at all-ones.
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != '1)) count_d = count_q + 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) count_q <= '0;
      else       count_q <= count_d;
   end

   assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_sequencer.sv
// Central pipeline control: arbitrates redirects, load-use bubbles and dmem wait
// states into PC select, stage enables/flushes and saturating stall/flush counters.
module pipeline_hazard_sequencer
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned MEM_TIMEOUT = 64,
   parameter int unsigned TO_W        = 7
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cond_taken_ex,
   input  logic             jalr_ex,
   input  logic             jal_id,
   input  logic             id_ex_mem_read,
   input  logic [4:0]       id_ex_rd,
   input  logic [4:0]       if_id_rs1,
   input  logic [4:0]       if_id_rs2,
   input  logic             rs1_used,
   input  logic             rs2_used,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic [2:0]       pc_src,
   output logic             pc_we,
   output logic             if_id_we,
   output logic             id_ex_we,
   output logic             ex_mem_we,
   output logic             mem_wb_we,
   output logic             if_id_reset,
   output logic             id_ex_reset,
   output logic             mem_fault,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   state_e          state_q, state_d;
   logic [TO_W-1:0] wait_q, wait_d;
   logic            fault_q;
   logic            load_use, mem_stall, redirect;

   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      case (state_q)
         ST_RUN: begin
            if (mem_req && !mem_ready) state_d = ST_MEM_WAIT;
            wait_d = '0;
         end
         ST_MEM_WAIT: begin
            if (mem_ready) begin
               state_d = ST_RUN;
               wait_d  = '0;
            end else begin
               wait_d = wait_q + 1'b1;
               if (wait_q == TO_W'(MEM_TIMEOUT - 1)) state_d = ST_FAULT;
            end
         end
         ST_FAULT: state_d = ST_FAULT;
         default:  state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_RUN;
         wait_q  <= '0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         fault_q <= fault_q | (state_d == ST_FAULT);
      end
   end

   assign mem_fault = fault_q;

   // Reset masks every hazard so the outputs show the plain RUN decode.
   assign load_use  = !reset && id_ex_mem_read && (id_ex_rd != 5'd0) &&
                      ((rs1_used && (if_id_rs1 == id_ex_rd)) ||
                       (rs2_used && (if_id_rs2 == id_ex_rd)));
   assign mem_stall = !reset && ((mem_req && !mem_ready) || (state_q != ST_RUN));

   always_comb begin
      pc_src      = PC_SEL_SEQ;
      pc_we       = 1'b1;
      if_id_we    = 1'b1;
      id_ex_we    = 1'b1;
      ex_mem_we   = 1'b1;
      mem_wb_we   = 1'b1;
      if_id_reset = 1'b0;
      id_ex_reset = 1'b0;
      redirect    = 1'b0;
      if (mem_stall) begin
         pc_we     = 1'b0;
         if_id_we  = 1'b0;
         id_ex_we  = 1'b0;
         ex_mem_we = 1'b0;
         mem_wb_we = 1'b0;
      end else if (!reset) begin
         // EX redirects squash the ID instruction, so they win over the load-use bubble.
         if (cond_taken_ex) begin
            pc_src      = PC_SEL_BR;
            if_id_reset = 1'b1;
            id_ex_reset = 1'b1;
            redirect    = 1'b1;
         end else if (jalr_ex) begin
            pc_src      = PC_SEL_JALR;
            if_id_reset = 1'b1;
            id_ex_reset = 1'b1;
            redirect    = 1'b1;
         end else if (load_use) begin
            pc_we       = 1'b0;
            if_id_we    = 1'b0;
            id_ex_reset = 1'b1;
         end else if (jal_id) begin
            pc_src      = PC_SEL_JAL;
            if_id_reset = 1'b1;
            redirect    = 1'b1;
         end
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (mem_stall | load_use),
      .count (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (redirect),
      .count (flush_cnt)
   );

endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// Directed bench for pipeline_hazard_sequencer with CNT_W=4, MEM_TIMEOUT=4.
module tb_pipeline_hazard_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       cond_taken_ex, jalr_ex, jal_id, id_ex_mem_read;
   logic [4:0] id_ex_rd, if_id_rs1, if_id_rs2;
   logic       rs1_used, rs2_used, mem_req, mem_ready;
   logic [2:0] pc_src;
   logic       pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
   logic       if_id_reset, id_ex_reset, mem_fault;
   logic [3:0] stall_cnt, flush_cnt;

   int checks = 0;
   int errors = 0;

   pipeline_hazard_sequencer #(
      .CNT_W       (4),
      .MEM_TIMEOUT (4),
      .TO_W        (3)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .cond_taken_ex  (cond_taken_ex),
      .jalr_ex        (jalr_ex),
      .jal_id         (jal_id),
      .id_ex_mem_read (id_ex_mem_read),
      .id_ex_rd       (id_ex_rd),
      .if_id_rs1      (if_id_rs1),
      .if_id_rs2      (if_id_rs2),
      .rs1_used       (rs1_used),
      .rs2_used       (rs2_used),
      .mem_req        (mem_req),
      .mem_ready      (mem_ready),
      .pc_src         (pc_src),
      .pc_we          (pc_we),
      .if_id_we       (if_id_we),
      .id_ex_we       (id_ex_we),
      .ex_mem_we      (ex_mem_we),
      .mem_wb_we      (mem_wb_we),
      .if_id_reset    (if_id_reset),
      .id_ex_reset    (id_ex_reset),
      .mem_fault      (mem_fault),
      .stall_cnt      (stall_cnt),
      .flush_cnt      (flush_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // we = {pc,if_id,id_ex,ex_mem,mem_wb}, fl = {if_id_reset,id_ex_reset}
   task automatic chk_dec(input string tag, input logic [2:0] pc, input logic [4:0] we,
                          input logic [1:0] fl);
      chk({tag, ".pc_src"}, 32'(pc_src), 32'(pc));
      chk({tag, ".we"}, 32'({pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we}), 32'(we));
      chk({tag, ".flush"}, 32'({if_id_reset, id_ex_reset}), 32'(fl));
   endtask

   task automatic chk_cnt(input string tag, input int st, input int fl);
      chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(st));
      chk({tag, ".flush_cnt"}, 32'(flush_cnt), 32'(fl));
   endtask

   task automatic idle();
      cond_taken_ex  = 1'b0;
      jalr_ex        = 1'b0;
      jal_id         = 1'b0;
      id_ex_mem_read = 1'b0;
      id_ex_rd       = 5'd0;
      if_id_rs1      = 5'd0;
      if_id_rs2      = 5'd0;
      rs1_used       = 1'b0;
      rs2_used       = 1'b0;
      mem_req        = 1'b0;
      mem_ready      = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_load(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                           input logic [4:0] rs2, input logic u2);
      id_ex_mem_read = 1'b1;
      id_ex_rd       = rd;
      if_id_rs1      = rs1;
      rs1_used       = u1;
      if_id_rs2      = rs2;
      rs2_used       = u2;
   endtask

   initial begin
      idle();
      reset = 1'b1;
      // Hazards presented under reset must not show through.
      cond_taken_ex = 1'b1;
      mem_req       = 1'b1;
      set_load(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
      #2;
      chk_dec("reset", 3'b000, 5'b11111, 2'b00);
      chk("reset.mem_fault", 32'(mem_fault), 32'd0);
      chk_cnt("reset", 0, 0);
      tick();
      tick();
      chk_cnt("reset_hold", 0, 0);
      idle();
      reset = 1'b0;
      #1;
      chk_dec("idle", 3'b000, 5'b11111, 2'b00);

      // Branch in EX beats JAL in ID.
      cond_taken_ex = 1'b1;
      jal_id        = 1'b1;
      #1;
      chk_dec("br_jal", 3'b001, 5'b11111, 2'b11);
      tick();
      chk_cnt("br_jal", 0, 1);
      idle();
      jalr_ex = 1'b1;
      #1;
      chk_dec("jalr", 3'b011, 5'b11111, 2'b11);
      tick();
      chk_cnt("jalr", 0, 2);
      idle();
      jal_id = 1'b1;
      #1;
      chk_dec("jal", 3'b010, 5'b11111, 2'b10);
      tick();
      chk_cnt("jal", 0, 3);

      // Load-use on rs2 (JAL in ID is held back by the bubble).
      idle();
      set_load(5'd5, 5'd0, 1'b0, 5'd5, 1'b1);
      jal_id = 1'b1;
      #1;
      chk_dec("lu_rs2", 3'b000, 5'b00111, 2'b01);
      tick();
      chk_cnt("lu_rs2", 1, 3);
      idle();
      set_load(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
      #1;
      chk_dec("lu_rd0", 3'b000, 5'b11111, 2'b00);
      tick();
      chk_cnt("lu_rd0", 1, 3);
      set_load(5'd7, 5'd7, 1'b1, 5'd3, 1'b0);
      #1;
      chk_dec("lu_rs1", 3'b000, 5'b00111, 2'b01);
      tick();
      chk_cnt("lu_rs1", 2, 3);
      rs1_used = 1'b0;
      #1;
      chk_dec("lu_unused", 3'b000, 5'b11111, 2'b00);
      tick();
      chk_cnt("lu_unused", 2, 3);
      // JALR in EX overrides load-use; the raw hazard still counts as a stall cycle.
      rs1_used = 1'b1;
      jalr_ex  = 1'b1;
      #1;
      chk_dec("jalr_lu", 3'b011, 5'b11111, 2'b11);
      tick();
      chk_cnt("jalr_lu", 3, 4);

      // Three wait cycles with JALR pending, then ready.
      idle();
      mem_req = 1'b1;
      jalr_ex = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         #1;
         chk_dec("memwait", 3'b000, 5'b00000, 2'b00);
         tick();
         chk_cnt("memwait", 3 + i, 4);
      end
      mem_ready = 1'b1;
      #1;
      chk_dec("mem_ready_cyc", 3'b000, 5'b00000, 2'b00);
      tick();
      chk_cnt("mem_ready_cyc", 7, 4);
      mem_req   = 1'b0;
      mem_ready = 1'b0;
      #1;
      chk_dec("post_wait_jalr", 3'b011, 5'b11111, 2'b11);
      tick();
      chk_cnt("post_wait_jalr", 7, 5);

      // Timeout: one RUN wait cycle plus MEM_TIMEOUT MEM_WAIT cycles.
      idle();
      mem_req = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         tick();
         chk("timeout.pre_fault", 32'(mem_fault), 32'd0);
      end
      tick();
      chk("timeout.fault", 32'(mem_fault), 32'd1);
      chk_cnt("timeout", 12, 5);
      mem_req   = 1'b0;
      mem_ready = 1'b1;
      jalr_ex   = 1'b1;
      #1;
      chk_dec("fault_hold", 3'b000, 5'b00000, 2'b00);
      tick();
      chk("fault_sticky", 32'(mem_fault), 32'd1);
      chk_cnt("fault_hold", 13, 5);
      idle();
      reset = 1'b1;
      #1;
      chk("fault_reset.mem_fault", 32'(mem_fault), 32'd0);
      chk_cnt("fault_reset", 0, 0);
      tick();
      reset = 1'b0;
      #1;
      chk_dec("fault_reset_run", 3'b000, 5'b11111, 2'b00);

      // Stall counter saturation: 2^4+3 load-use cycles.
      set_load(5'd9, 5'd9, 1'b1, 5'd0, 1'b0);
      for (int i = 1; i <= 19; i++) begin
         tick();
         chk("sat.stall_cnt", 32'(stall_cnt), 32'((i < 15) ? i : 15));
      end
      idle();
      cond_taken_ex = 1'b1;
      for (int i = 1; i <= 19; i++) begin
         tick();
         chk("sat.flush_cnt", 32'(flush_cnt), 32'((i < 15) ? i : 15));
      end

      // Asynchronous reset in the middle of a wait.
      idle();
      mem_req = 1'b1;
      tick();
      tick();
      #1;
      chk_dec("async.pre", 3'b000, 5'b00000, 2'b00);
      reset = 1'b1;
      #1;
      chk_cnt("async", 0, 0);
      chk("async.mem_fault", 32'(mem_fault), 32'd0);
      chk_dec("async.in_reset", 3'b000, 5'b11111, 2'b00);
      reset   = 1'b0;
      mem_req = 1'b0;
      #1;
      chk_dec("async.run", 3'b000, 5'b11111, 2'b00);
      tick();
      chk_cnt("async.after", 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
